// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared widths, FSM state encoding and default hazard timings
package fetch_ctrl_pkg;
  localparam int LENGTH_INSTR_MEM = 10;
  localparam int DEF_LOAD_STALL = 2;
  localparam int DEF_FLUSH_CYCLES = 2;
  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10,
    HALT  = 2'b11
  } state_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: hazard events in, PC / pipeline-register controls and status out
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;
  logic                        iBr_taken;
  logic [LENGTH_INSTR_MEM-1:0] iBr_dir;
  logic                        iLoad_use;
  logic                        iHalt;
  logic                        oPc_en;
  logic                        oPc_load;
  logic [LENGTH_INSTR_MEM-1:0] oPc_dir;
  logic                        oIfId_hold;
  logic                        oIfId_flush;
  logic                        oIdEx_bubble;
  logic [1:0]                  oState;
  logic [15:0]                 oStall_cnt;
  logic [15:0]                 oFlush_cnt;
  modport master (
    output iBr_taken, iBr_dir, iLoad_use, iHalt,
    input  oPc_en, oPc_load, oPc_dir, oIfId_hold, oIfId_flush, oIdEx_bubble,
           oState, oStall_cnt, oFlush_cnt
  );
  modport slave (
    input  iBr_taken, iBr_dir, iLoad_use, iHalt,
    output oPc_en, oPc_load, oPc_dir, oIfId_hold, oIfId_flush, oIdEx_bubble,
           oState, oStall_cnt, oFlush_cnt
  );
endinterface

// File: rtl/fetch_ctrl_sat_counter16.sv
// sat_counter16: 16-bit event counter that sticks at all-ones
module sat_counter16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] q
);
  logic [15:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (en && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  assign q = cnt;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage hazard FSM; a taken branch flushes, a load-use hazard
// or halt holds the front end, outputs decoded combinationally from state
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int LOAD_STALL   = DEF_LOAD_STALL,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input logic         clk,
  input logic         reset,
  fetch_ctrl_if.slave bus
);
  state_t     state;
  logic [3:0] dcnt;
  logic       br, hold, flush, stall_inc;
  always_comb begin
    br = reset && bus.iBr_taken;
    hold = reset && !bus.iBr_taken && (state == STALL || state == HALT ||
           (state == RUN && (bus.iLoad_use || bus.iHalt)));
    stall_inc = reset && !bus.iBr_taken &&
                (state == STALL || (state == RUN && bus.iLoad_use));
    flush = br || (reset && state == FLUSH);
    bus.oPc_en = reset && !hold;
    bus.oPc_load = br;
    bus.oPc_dir = br ? bus.iBr_dir : '0;
    bus.oIfId_hold = hold;
    bus.oIfId_flush = flush;
    bus.oIdEx_bubble = flush || hold;
    bus.oState = state;
  end
  // dcnt holds the remaining extra cycles; FLUSH leaves once it would reach zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= RUN;
      dcnt <= '0;
    end else if (bus.iBr_taken) begin
      state <= FLUSH_CYCLES > 1 ? FLUSH : RUN;
      dcnt <= 4'(FLUSH_CYCLES - 1);
    end else
      case (state)
        RUN:
          if (bus.iLoad_use) begin
            state <= LOAD_STALL > 1 ? STALL : RUN;
            dcnt <= LOAD_STALL > 1 ? 4'(LOAD_STALL - 2) : 4'd0;
          end else if (bus.iHalt) state <= HALT;
        STALL: begin
          state <= dcnt == 4'd0 ? RUN : STALL;
          dcnt <= dcnt == 4'd0 ? 4'd0 : dcnt - 4'd1;
        end
        FLUSH: begin
          state <= dcnt > 4'd1 ? FLUSH : (bus.iHalt ? HALT : RUN);
          dcnt <= dcnt == 4'd0 ? 4'd0 : dcnt - 4'd1;
        end
        HALT: state <= bus.iHalt ? HALT : RUN;
      endcase
  sat_counter16 u_stall (.clk(clk), .reset(reset), .en(stall_inc), .q(bus.oStall_cnt));
  sat_counter16 u_flush (.clk(clk), .reset(reset), .en(br), .q(bus.oFlush_cnt));
endmodule
